// File: rtl/mapper_ctx_sequencer.sv
// Shadow-context save/restore sequencer for the 4510 user mapper registers (A,X,Y,Z).
// Save walks the mapper readback select; restore drives the hypervisor user-register load path.
module mapper_ctx_sequencer #(
  parameter int unsigned NUM_CTX = 4,
  parameter int unsigned CW      = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_save_req,
  input  logic          i_restore_req,
  input  logic          i_abort,
  input  logic [CW-1:0] i_ctx_idx,
  input  logic          i_mapper_map,
  input  logic [7:0]    i_map_reg_data,
  output logic [1:0]    o_map_rd_sel,
  output logic          o_hv_load_user_reg,
  output logic [1:0]    o_hv_write_sel,
  output logic [7:0]    o_hv_wdata,
  output logic          o_busy,
  output logic          o_done,
  input  logic [CW-1:0] i_ctx_rd_idx,
  input  logic [1:0]    i_ctx_rd_sel,
  output logic [7:0]    o_ctx_rd_data
);

  typedef enum logic [1:0] {StIdle, StSave, StRestore, StDone} state_e;

  state_e        r_state, w_state_d;
  logic [1:0]    r_cnt, w_cnt_d;
  logic [CW-1:0] r_cur_ctx, w_cur_ctx_d;
  logic          w_capture;
  logic [1:0]    w_sel;
  logic [7:0]    r_shadow [NUM_CTX][4];

  // Registers are walked A first, so the select is the inverted count.
  assign w_sel         = ~r_cnt;
  assign o_ctx_rd_data = r_shadow[i_ctx_rd_idx][i_ctx_rd_sel];

  always_comb begin
    w_state_d          = r_state;
    w_cnt_d            = r_cnt;
    w_cur_ctx_d        = r_cur_ctx;
    w_capture          = 1'b0;
    o_map_rd_sel       = 2'd0;
    o_hv_load_user_reg = 1'b0;
    o_hv_write_sel     = 2'd0;
    o_hv_wdata         = 8'h00;
    o_busy             = 1'b0;
    o_done             = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_save_req) begin
          w_state_d   = StSave;
          w_cur_ctx_d = i_ctx_idx;
          w_cnt_d     = 2'd0;
        end else if (i_restore_req) begin
          w_state_d   = StRestore;
          w_cur_ctx_d = i_ctx_idx;
          w_cnt_d     = 2'd0;
        end
      end
      StSave: begin
        o_busy       = 1'b1;
        o_map_rd_sel = w_sel;
        if (i_abort) begin
          w_state_d = StIdle;
        end else begin
          w_capture = 1'b1;
          w_cnt_d   = r_cnt + 2'd1;
          if (r_cnt == 2'd3) w_state_d = StDone;
        end
      end
      StRestore: begin
        o_busy         = 1'b1;
        o_hv_write_sel = w_sel;
        o_hv_wdata     = r_shadow[r_cur_ctx][w_sel];
        if (i_abort) begin
          w_state_d = StIdle;
        end else if (!i_mapper_map) begin
          // Mapper accepts writes only while no MAP instruction is in flight.
          o_hv_load_user_reg = 1'b1;
          w_cnt_d            = r_cnt + 2'd1;
          if (r_cnt == 2'd3) w_state_d = StDone;
        end
      end
      StDone: begin
        o_done    = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_cnt     <= 2'd0;
      r_cur_ctx <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_cur_ctx <= w_cur_ctx_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < NUM_CTX; c++) begin
        for (int r = 0; r < 4; r++) begin
          r_shadow[c][r] <= 8'h00;
        end
      end
    end else if (w_capture) begin
      r_shadow[r_cur_ctx][w_sel] <= i_map_reg_data;
    end
  end

endmodule

// File: tb/tb_mapper_ctx_sequencer.sv
// Directed self-checking bench for mapper_ctx_sequencer; a tiny mapper register model
// answers the readback select so save results can be checked against constants.
module tb_mapper_ctx_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       save_req = 1'b0, restore_req = 1'b0, abort = 1'b0;
  logic [1:0] ctx_idx = 2'd0;
  logic       mapper_map = 1'b0;
  logic [7:0] map_reg_data;
  logic [1:0] map_rd_sel;
  logic       hv_load_user_reg;
  logic [1:0] hv_write_sel;
  logic [7:0] hv_wdata;
  logic       busy, done;
  logic [1:0] ctx_rd_idx = 2'd0, ctx_rd_sel = 2'd0;
  logic [7:0] ctx_rd_data;

  logic [7:0] model [4];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign map_reg_data = model[map_rd_sel];

  mapper_ctx_sequencer #(.NUM_CTX(4), .CW(2)) u_dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_save_req         (save_req),
    .i_restore_req      (restore_req),
    .i_abort            (abort),
    .i_ctx_idx          (ctx_idx),
    .i_mapper_map       (mapper_map),
    .i_map_reg_data     (map_reg_data),
    .o_map_rd_sel       (map_rd_sel),
    .o_hv_load_user_reg (hv_load_user_reg),
    .o_hv_write_sel     (hv_write_sel),
    .o_hv_wdata         (hv_wdata),
    .o_busy             (busy),
    .o_done             (done),
    .i_ctx_rd_idx       (ctx_rd_idx),
    .i_ctx_rd_sel       (ctx_rd_sel),
    .o_ctx_rd_data      (ctx_rd_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] idx, input logic [1:0] sel,
                          input logic [7:0] exp);
    ctx_rd_idx = idx;
    ctx_rd_sel = sel;
    #1;
    check_eq(tag, {24'h0, ctx_rd_data}, {24'h0, exp});
  endtask

  logic [7:0] slot1 [4];
  logic [7:0] slot2 [4];

  initial begin
    int nstrobe;
    int ndone;
    // Order A,X,Y,Z, i.e. select 3,2,1,0.
    slot1[0] = 8'h12; slot1[1] = 8'h34; slot1[2] = 8'h56; slot1[3] = 8'h78;
    slot2[0] = 8'hAA; slot2[1] = 8'hBB; slot2[2] = 8'hCC; slot2[3] = 8'hDD;
    model[3] = 8'h12; model[2] = 8'h34; model[1] = 8'h56; model[0] = 8'h78;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_busy", {31'h0, busy}, 32'd0);
    check_eq("rst_done", {31'h0, done}, 32'd0);
    check_eq("rst_load", {31'h0, hv_load_user_reg}, 32'd0);
    check_eq("rst_rd_sel", {30'h0, map_rd_sel}, 32'd0);
    check_eq("rst_wr_sel", {30'h0, hv_write_sel}, 32'd0);
    check_eq("rst_wdata", {24'h0, hv_wdata}, 32'd0);
    rd_check("rst_shadow", 2'd1, 2'd3, 8'h00);

    // Test 1: save into slot 1.
    cyc();
    save_req = 1'b1; ctx_idx = 2'd1;
    #1;
    check_eq("t1_idle_busy", {31'h0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      save_req = 1'b0;
      #1;
      check_eq("t1_busy", {31'h0, busy}, 32'd1);
      check_eq("t1_rd_sel", {30'h0, map_rd_sel}, 32'(3 - i));
      check_eq("t1_load", {31'h0, hv_load_user_reg}, 32'd0);
      if (i == 0) rd_check("t1_old_before_edge", 2'd1, 2'd3, 8'h00);
    end
    cyc();
    #1;
    check_eq("t1_done", {31'h0, done}, 32'd1);
    check_eq("t1_done_busy", {31'h0, busy}, 32'd0);
    cyc();
    #1;
    check_eq("t1_done_clear", {31'h0, done}, 32'd0);
    for (int i = 0; i < 4; i++) rd_check("t1_shadow", 2'd1, 2'(3 - i), slot1[i]);

    // Test 2: restore slot 1 with the mapper idle.
    cyc();
    restore_req = 1'b1; ctx_idx = 2'd1; mapper_map = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      restore_req = 1'b0;
      #1;
      check_eq("t2_load", {31'h0, hv_load_user_reg}, 32'd1);
      check_eq("t2_sel", {30'h0, hv_write_sel}, 32'(3 - i));
      check_eq("t2_data", {24'h0, hv_wdata}, {24'h0, slot1[i]});
    end
    cyc();
    #1;
    check_eq("t2_done", {31'h0, done}, 32'd1);
    check_eq("t2_done_load", {31'h0, hv_load_user_reg}, 32'd0);
    check_eq("t2_done_wdata", {24'h0, hv_wdata}, 32'd0);

    // Test 3: mapper busy in operation cycles 2-4.
    cyc();
    restore_req = 1'b1; ctx_idx = 2'd1;
    #1;
    nstrobe = 0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      restore_req = 1'b0;
      mapper_map = (k >= 2 && k <= 4);
      #1;
      check_eq("t3_no_early_done", {31'h0, done}, 32'd0);
      if (hv_load_user_reg) begin
        if (nstrobe < 4) begin
          check_eq("t3_sel", {30'h0, hv_write_sel}, 32'(3 - nstrobe));
          check_eq("t3_data", {24'h0, hv_wdata}, {24'h0, slot1[nstrobe]});
        end
        nstrobe++;
      end
    end
    check_eq("t3_strobes", 32'(nstrobe), 32'd4);
    cyc();
    mapper_map = 1'b0;
    #1;
    check_eq("t3_done", {31'h0, done}, 32'd1);

    // Test 4: simultaneous requests -> save wins; second save while busy ignored.
    model[3] = 8'hAA; model[2] = 8'hBB; model[1] = 8'hCC; model[0] = 8'hDD;
    cyc();
    save_req = 1'b1; restore_req = 1'b1; ctx_idx = 2'd2;
    #1;
    nstrobe = 0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      save_req = (k == 2); restore_req = 1'b0; ctx_idx = (k == 2) ? 2'd3 : 2'd2;
      #1;
      if (hv_load_user_reg) nstrobe++;
      check_eq("t4_rd_sel", {30'h0, map_rd_sel}, 32'(4 - k));
    end
    save_req = 1'b0;
    check_eq("t4_no_strobes", 32'(nstrobe), 32'd0);
    cyc();
    #1;
    check_eq("t4_done", {31'h0, done}, 32'd1);
    cyc();
    #1;
    check_eq("t4_not_queued", {31'h0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) rd_check("t4_shadow2", 2'd2, 2'(3 - i), slot2[i]);
    rd_check("t4_slot3_untouched", 2'd3, 2'd3, 8'h00);
    rd_check("t4_slot1_intact", 2'd1, 2'd0, 8'h78);

    // Test 5a: abort restore of slot 2 after two writes.
    cyc();
    restore_req = 1'b1; ctx_idx = 2'd2;
    #1;
    nstrobe = 0;
    ndone = 0;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      restore_req = 1'b0;
      abort = (k == 3);
      #1;
      if (hv_load_user_reg) begin
        if (nstrobe < 2) check_eq("t5_data", {24'h0, hv_wdata}, {24'h0, slot2[nstrobe]});
        nstrobe++;
      end
    end
    cyc();
    abort = 1'b0;
    #1;
    check_eq("t5_abort_busy", {31'h0, busy}, 32'd0);
    if (done) ndone++;
    cyc();
    #1;
    if (done) ndone++;
    check_eq("t5_strobes", 32'(nstrobe), 32'd2);
    check_eq("t5_no_done", 32'(ndone), 32'd0);
    // Abort in idle has no effect.
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    #1;
    check_eq("t5_idle_abort", {31'h0, busy}, 32'd0);

    // Test 5b: async reset in the middle of a save.
    save_req = 1'b1; ctx_idx = 2'd0;
    cyc();
    save_req = 1'b0;
    cyc();
    #1;
    check_eq("t5_save_busy", {31'h0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("t5_rst_busy", {31'h0, busy}, 32'd0);
    check_eq("t5_rst_rd_sel", {30'h0, map_rd_sel}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) rd_check("t5_rst_shadow", 2'(c), 2'(r), 8'h00);
    end
    @(negedge clk);
    reset = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
